// File: rtl/fifo_to_mem_mq.sv
// Drains a packet-framed, queue-tagged FIFO into NUM_QUEUES circular memory regions.
// Each packet is accepted or dropped once, on its first word, using a headroom check.
module fifo_to_mem_mq #(
  parameter int NUM_QUEUES       = 4,
  parameter int NUM_QUEUES_BITS  = $clog2(NUM_QUEUES),
  parameter int FIFO_DATA_WIDTH  = 144,
  parameter int MEM_ADDR_WIDTH   = 19,
  parameter int MEM_BW_WIDTH     = 8,
  parameter int QUEUE_ADDR_WIDTH = MEM_ADDR_WIDTH - NUM_QUEUES_BITS,
  parameter int HEADROOM         = 64,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]             fifo_data,
  input  logic [NUM_QUEUES_BITS-1:0]             fifo_qid,
  input  logic                                   fifo_eop,
  input  logic                                   fifo_empty,
  output logic                                   mem_ad_w_n,
  output logic                                   mem_d_w_n,
  input  logic                                   mem_wr_full,
  output logic [MEM_ADDR_WIDTH-1:0]              mem_ad_wr,
  output logic [FIFO_DATA_WIDTH/2-1:0]           mem_dwl,
  output logic [FIFO_DATA_WIDTH/2-1:0]           mem_dwh,
  output logic [MEM_BW_WIDTH-1:0]                mem_bwl_n,
  output logic [MEM_BW_WIDTH-1:0]                mem_bwh_n,
  input  logic [NUM_QUEUES*QUEUE_ADDR_WIDTH-1:0] q_addr_head,
  output logic [NUM_QUEUES*QUEUE_ADDR_WIDTH-1:0] q_addr_tail,
  input  logic [NUM_QUEUES-1:0]                  q_clear,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]        drop_cnt,
  input  logic                                   cal_done
);

  localparam int QAW  = QUEUE_ADDR_WIDTH;
  localparam int HALF = FIFO_DATA_WIDTH / 2;
  localparam logic [QAW:0] HR = (QAW+1)'(HEADROOM);

  typedef enum logic [1:0] {IDLE, WR_PKT, DROP} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                         state_r, state_nxt;
  logic [NUM_QUEUES_BITS-1:0]     cur_q_r, cur_q_nxt;
  logic [NUM_QUEUES*QAW-1:0]      tail_r, tail_nxt;
  logic [NUM_QUEUES*CNT_WIDTH-1:0] drop_r, drop_nxt;
  logic                           pop, wr, drop_inc;

  logic [QAW-1:0] sel_tail, sel_head, used, free, cur_tail;
  logic           has_room;

  assign sel_tail = tail_r[fifo_qid*QAW +: QAW];
  assign sel_head = q_addr_head[fifo_qid*QAW +: QAW];
  assign used     = sel_tail - sel_head;
  assign free     = {QAW{1'b1}} - used;
  assign has_room = {1'b0, free} >= HR;
  assign cur_tail = tail_r[cur_q_r*QAW +: QAW];

  always_comb begin
    state_nxt = state_r;
    cur_q_nxt = cur_q_r;
    pop       = 1'b0;
    wr        = 1'b0;
    drop_inc  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty && cal_done) begin
          cur_q_nxt = fifo_qid;
          if (has_room && !q_clear[fifo_qid]) begin
            state_nxt = WR_PKT;
          end else begin
            state_nxt = DROP;
            drop_inc  = 1'b1;
          end
        end
      end
      WR_PKT: begin
        // A clear on the active queue abandons the rest of the packet.
        if (q_clear[cur_q_r]) begin
          state_nxt = DROP;
        end else if (!fifo_empty && !mem_wr_full && cal_done) begin
          pop = 1'b1;
          wr  = 1'b1;
          if (fifo_eop) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (fifo_eop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tail_nxt = tail_r;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (q_clear[i]) begin
        tail_nxt[i*QAW +: QAW] = '0;
      end else if (wr && (cur_q_r == NUM_QUEUES_BITS'(i))) begin
        tail_nxt[i*QAW +: QAW] = tail_r[i*QAW +: QAW] + QAW'(1);
      end
    end
  end

  always_comb begin
    drop_nxt = drop_r;
    if (drop_inc) begin
      drop_nxt[fifo_qid*CNT_WIDTH +: CNT_WIDTH] = sat_inc(drop_r[fifo_qid*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cur_q_r <= '0;
      tail_r  <= '0;
      drop_r  <= '0;
    end else begin
      state_r <= state_nxt;
      cur_q_r <= cur_q_nxt;
      tail_r  <= tail_nxt;
      drop_r  <= drop_nxt;
    end
  end

  // p1: memory write stage, one cycle after the pop
  logic                      wr_vld_p1;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_p1;
  logic [HALF-1:0]           wr_dwl_p1, wr_dwh_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_dwl_p1  <= '0;
      wr_dwh_p1  <= '0;
    end else begin
      wr_vld_p1 <= wr;
      if (wr) begin
        wr_addr_p1 <= {cur_q_r, cur_tail};
        wr_dwl_p1  <= fifo_data[HALF-1:0];
        wr_dwh_p1  <= fifo_data[FIFO_DATA_WIDTH-1:HALF];
      end
    end
  end

  assign fifo_rd_en  = pop && !rst;
  assign mem_ad_w_n  = ~wr_vld_p1;
  assign mem_d_w_n   = ~wr_vld_p1;
  assign mem_ad_wr   = wr_addr_p1;
  assign mem_dwl     = wr_dwl_p1;
  assign mem_dwh     = wr_dwh_p1;
  assign mem_bwl_n   = '0;
  assign mem_bwh_n   = '0;
  assign q_addr_tail = tail_r;
  assign drop_cnt    = drop_r;

endmodule
